rr_request_arbiter: RTL

//   Round-robin arbiter sharing one resource between NREQ requesters.
//   - Latches one winner from a request vector and holds the grant until the owner finishes.
//   - Presents the winner both one-hot and binary-encoded, for the downstream resource mux/decoder.
//   - Rotating priority pointer prevents starvation; optional hold limit bounds ownership time.

---
 rtl/rr_request_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rr_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_request_arbiter
//  Description : Round-robin arbiter sharing one resource between NREQ
//                requesters. A winner is latched from the request vector and
//                keeps the grant until it releases, withdraws its request or
//                (optionally) exceeds MAX_HOLD cycles of ownership. Every
//                ownership is followed by one idle turnaround cycle.
//  Ports       : i_clk        - clock, rising edge
//                i_reset      - asynchronous reset, active-high
//                i_req        - request vector, bit k = requester k
//                i_release    - owner is done with the resource (BUSY only)
//                o_grant      - registered one-hot grant, zero when no owner
//                o_grant_idx  - binary owner index, valid while o_valid=1
//                o_valid      - resource currently owned
//                o_timeout    - one-cycle pulse when MAX_HOLD revoked a grant
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_request_arbiter #(
    parameter int NREQ     = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_release,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_valid,
    output logic             o_timeout
);

    // Counter is at least one bit wide so the unlimited configuration elaborates.
    localparam int                 c_CNT_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = '1;
    localparam logic [IDX_W:0]     c_NREQ_EXT  = (IDX_W + 1)'(NREQ);
    localparam logic [IDX_W-1:0]   c_LAST_IDX  = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             r_state_q,   w_state_d;
    logic [IDX_W-1:0]   r_ptr_q,     w_ptr_d;
    logic [c_CNT_W-1:0] r_cnt_q,     w_cnt_d;
    logic [NREQ-1:0]    r_grant_q,   w_grant_d;
    logic [IDX_W-1:0]   r_idx_q,     w_idx_d;
    logic               r_timeout_q, w_timeout_d;

    logic [NREQ-1:0]    w_req_rot;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W:0]     w_sum;
    logic [IDX_W-1:0]   w_winner;
    logic               w_owner_req;
    logic               w_free_cause;
    logic               w_expire;

    // Rotate the request vector so the pointer position lands at bit 0; the
    // lowest set bit of the rotated vector is then the round-robin winner's
    // offset from the pointer.
    always_comb begin
        w_req_rot = NREQ'({i_req, i_req} >> r_ptr_q);
        w_off     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
        w_sum = {1'b0, r_ptr_q} + {1'b0, w_off};
        if (w_sum >= c_NREQ_EXT) begin
            w_winner = IDX_W'(w_sum - c_NREQ_EXT);
        end else begin
            w_winner = IDX_W'(w_sum);
        end
    end

    // Release and withdrawal outrank expiry when deciding whether o_timeout fires.
    assign w_owner_req  = |(i_req & r_grant_q);
    assign w_free_cause = i_release || !w_owner_req;
    assign w_expire     = (MAX_HOLD != 0) && (r_cnt_q == c_HOLD_LAST);

    always_comb begin
        w_state_d   = r_state_q;
        w_ptr_d     = r_ptr_q;
        w_cnt_d     = r_cnt_q;
        w_grant_d   = r_grant_q;
        w_idx_d     = r_idx_q;
        w_timeout_d = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    w_state_d = ST_BUSY;
                    w_grant_d = NREQ'(1) << w_winner;
                    w_idx_d   = w_winner;
                    w_cnt_d   = '0;
                    w_ptr_d   = (w_winner == c_LAST_IDX) ? '0 : w_winner + 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_free_cause || w_expire) begin
                    w_state_d   = ST_GAP;
                    w_grant_d   = '0;
                    w_cnt_d     = '0;
                    w_timeout_d = w_expire && !w_free_cause;
                end else if (r_cnt_q != c_CNT_MAX) begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state_q   <= ST_IDLE;
            r_ptr_q     <= '0;
            r_cnt_q     <= '0;
            r_grant_q   <= '0;
            r_idx_q     <= '0;
            r_timeout_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_ptr_q     <= w_ptr_d;
            r_cnt_q     <= w_cnt_d;
            r_grant_q   <= w_grant_d;
            r_idx_q     <= w_idx_d;
            r_timeout_q <= w_timeout_d;
        end
    end

    assign o_grant     = r_grant_q;
    assign o_grant_idx = r_idx_q;
    assign o_valid     = (r_state_q == ST_BUSY);
    assign o_timeout   = r_timeout_q;

endmodule
`default_nettype wire
